// File: rtl/wb_arbiter.sv
// wb_arbiter
// Writeback arbiter feeding the register file's single write port.
//   Port A : single-cycle pipeline results (a_valid/a_ready/a_rd/a_data)
//   Port B : long-latency results (b_valid/b_ready/b_rd/b_data)
//   Output : one registered write per cycle (rf_we/rf_wr/rf_wd)
//   Scoreboard : sb_set/sb_rd mark a long-latency destination pending;
//                busy_rs1/busy_rs2 report pending sources to decode;
//                sb_err is a sticky double-issue flag.
// Port A normally wins.  Port B is forced through once it has waited
// STARVE_LIMIT consecutive cycles, which stalls A for that one cycle.
module wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  input  logic        sb_set,
  input  logic [4:0]  sb_rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        busy_rs1,
  output logic        busy_rs2,
  output logic        sb_err,
  output logic        rf_we,
  output logic [4:0]  rf_wr,
  output logic [31:0] rf_wd
);

  typedef enum logic {
    REGWE_NONE  = 1'b0,
    REGWE_WRITE = 1'b1
  } regwe_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  starve_cnt;
  logic        force_b;
  logic        acc_a;
  logic        acc_b;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;

  regwe_e      we_q;
  logic        wb_src_b;

  logic [31:1] pending;
  logic [31:0] pend_full;
  logic [31:0] clr_vec;
  logic [31:0] set_vec;
  logic [31:0] pend_next;
  logic        sb_dup;
  logic        sb_err_q;

  // Arbitration
  assign force_b = b_valid && (starve_cnt == LIMIT);
  assign a_ready = !force_b;
  assign b_ready = force_b || !a_valid;
  assign acc_a   = a_valid && a_ready;
  assign acc_b   = b_valid && b_ready;

  always_comb begin
    sel_rd   = a_rd;
    sel_data = a_data;
    if (acc_b) begin
      sel_rd   = b_rd;
      sel_data = b_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!b_valid || acc_b) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Registered write stage; address/data hold when nothing is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= REGWE_NONE;
      rf_wr    <= '0;
      rf_wd    <= '0;
      wb_src_b <= 1'b0;
    end else if (acc_a || acc_b) begin
      we_q     <= (sel_rd != '0) ? REGWE_WRITE : REGWE_NONE;
      rf_wr    <= sel_rd;
      rf_wd    <= sel_data;
      wb_src_b <= acc_b;
    end else begin
      we_q <= REGWE_NONE;
    end
  end

  assign rf_we = (we_q == REGWE_WRITE);

  // Scoreboard: the live B write clears its bit on the edge it commits;
  // applying set after clear makes a same-edge set win.
  assign pend_full = {pending, 1'b0};

  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    if (we_q == REGWE_WRITE && wb_src_b) clr_vec[rf_wr] = 1'b1;
    if (sb_set && sb_rd != '0) set_vec[sb_rd] = 1'b1;
    pend_next = (pend_full & ~clr_vec) | set_vec;
  end

  assign sb_dup = sb_set && (sb_rd != '0) && pend_full[sb_rd] && !clr_vec[sb_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      sb_err_q <= 1'b0;
    end else begin
      pending <= pend_next[31:1];
      if (sb_dup) sb_err_q <= 1'b1;
    end
  end

  assign sb_err   = sb_err_q;
  assign busy_rs1 = pend_full[rs1];
  assign busy_rs2 = pend_full[rs2];

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, sb_set;
  logic        a_ready, b_ready;
  logic [4:0]  a_rd, b_rd, sb_rd, rs1, rs2;
  logic [31:0] a_data, b_data;
  logic        busy_rs1, busy_rs2, sb_err;
  logic        rf_we;
  logic [4:0]  rf_wr;
  logic [31:0] rf_wd;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .sb_set(sb_set), .sb_rd(sb_rd), .rs1(rs1), .rs2(rs2),
    .busy_rs1(busy_rs1), .busy_rs2(busy_rs2), .sb_err(sb_err),
    .rf_we(rf_we), .rf_wr(rf_wr), .rf_wd(rf_wd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the register file will see, which registers are
  // still owed a long-latency result, and how long B has been kept waiting.
  bit          m_pend [32];
  int          m_waited;
  bit          m_err;
  bit          m_we;
  bit          m_from_b;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;
  bit          m_acc_a, m_acc_b;

  always @(negedge clk) begin : compare
    bit ea_ready, eb_ready, ga, gb, commit_b;
    logic [4:0] committing;
    if (!rst_n) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_waited = 0; m_err = 1'b0; m_we = 1'b0; m_from_b = 1'b0;
      m_wr = '0; m_wd = '0; m_acc_a = 1'b0; m_acc_b = 1'b0;
      chk("rst_rf_we", rf_we, 0);
      chk("rst_rf_wr", rf_wr, 0);
      chk("rst_rf_wd", rf_wd, 0);
      chk("rst_sb_err", sb_err, 0);
      chk("rst_busy1", busy_rs1, 0);
      chk("rst_busy2", busy_rs2, 0);
      chk("rst_a_ready", a_ready, 1);
      chk("rst_b_ready", b_ready, !a_valid);
    end else begin
      // B gets the port if A is idle, or if it has already waited LIMIT cycles
      ea_ready = !(b_valid && m_waited >= LIMIT);
      eb_ready = !a_valid || !ea_ready;
      ga = a_valid && ea_ready;
      gb = b_valid && eb_ready;
      chk("a_ready", a_ready, ea_ready);
      chk("b_ready", b_ready, eb_ready);
      chk("busy_rs1", busy_rs1, (rs1 != 0) && m_pend[rs1]);
      chk("busy_rs2", busy_rs2, (rs2 != 0) && m_pend[rs2]);
      chk("sb_err", sb_err, m_err);
      chk("rf_we", rf_we, m_we);
      chk("rf_wr", rf_wr, m_wr);
      chk("rf_wd", rf_wd, m_wd);
      // next edge
      commit_b   = m_we && m_from_b;
      committing = m_wr;
      if (sb_set && sb_rd != 0 && m_pend[sb_rd] && !(commit_b && committing == sb_rd))
        m_err = 1'b1;
      if (commit_b) m_pend[committing] = 1'b0;
      if (sb_set && sb_rd != 0) m_pend[sb_rd] = 1'b1;
      if (!b_valid || gb) m_waited = 0;
      else if (m_waited < LIMIT) m_waited++;
      if (ga) begin
        m_we = (a_rd != 0); m_wr = a_rd; m_wd = a_data; m_from_b = 1'b0;
      end else if (gb) begin
        m_we = (b_rd != 0); m_wr = b_rd; m_wd = b_data; m_from_b = 1'b1;
      end else begin
        m_we = 1'b0;
      end
      m_acc_a = ga;
      m_acc_b = gb;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 0; b_valid = 0; sb_set = 0;
    a_rd = '0; b_rd = '0; sb_rd = '0; a_data = '0; b_data = '0;
  endtask

  int j;

  initial begin
    rst_n = 1'b1;
    idle_inputs();
    rs1 = '0; rs2 = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single A write
    a_valid = 1; a_rd = 5; a_data = 32'hDEADBEEF;
    #1 chk("t1_a_ready", a_ready, 1);
    step();
    a_valid = 0;
    #1;
    chk("t1_we", rf_we, 1); chk("t1_wr", rf_wr, 5); chk("t1_wd", rf_wd, 32'hDEADBEEF);
    step();
    chk("t1_we_off", rf_we, 0);

    // Collision: A first, then B
    a_valid = 1; a_rd = 3; a_data = 32'h33;
    b_valid = 1; b_rd = 4; b_data = 32'h44;
    #1 chk("t2_b_ready", b_ready, 0);
    step();
    a_valid = 0;
    #1;
    chk("t2_wr_a", rf_wr, 3); chk("t2_b_ready2", b_ready, 1);
    step();
    b_valid = 0;
    chk("t2_wr_b", rf_wr, 4); chk("t2_wd_b", rf_wd, 32'h44);
    step();

    // Starvation: B forced through on its 5th waiting cycle
    j = 0;
    b_valid = 1; b_rd = 12; b_data = 32'hB0;
    for (int i = 1; i <= 10; i++) begin
      a_valid = 1; a_rd = 10; a_data = 32'hA000 + j;
      #1 chk("t3_a_ready", a_ready, (i != 5));
      step();
      if (i == 5) begin
        b_valid = 0;
        chk("t3_wd_b", rf_wd, 32'hB0);
      end else begin
        chk("t3_wd_a", rf_wd, 32'hA000 + j);
        j++;
      end
    end
    a_valid = 0;
    step();

    // Scoreboard busy through commit edge
    sb_set = 1; sb_rd = 7; rs1 = 7; rs2 = 0;
    step();
    sb_set = 0;
    #1 chk("t4_busy", busy_rs1, 1); chk("t4_rs2_zero", busy_rs2, 0);
    step();
    b_valid = 1; b_rd = 7; b_data = 32'h77;
    #1 chk("t4_busy_acc", busy_rs1, 1);
    step();
    b_valid = 0;
    #1 chk("t4_busy_n1", busy_rs1, 1);
    step();
    chk("t4_busy_n2", busy_rs1, 0);
    rs1 = 0;
    #1 chk("t4_rs1_zero", busy_rs1, 0);

    // Set on commit edge keeps bit, no error; then a true duplicate
    sb_set = 1; sb_rd = 9; rs1 = 9;
    step();
    sb_set = 0; b_valid = 1; b_rd = 9; b_data = 32'h99;
    step();
    b_valid = 0; sb_set = 1; sb_rd = 9;
    step();
    sb_set = 0;
    #1 chk("t5_pend9", busy_rs1, 1); chk("t5_no_err", sb_err, 0);
    sb_set = 1; sb_rd = 9;
    step();
    sb_set = 0;
    chk("t5_err", sb_err, 1);
    repeat (3) step();
    chk("t5_err_sticky", sb_err, 1);

    // Write to x0 and async reset with pending bits
    b_valid = 1; b_rd = 0; b_data = 32'h1234;
    #1 chk("t6_b_ready", b_ready, 1);
    step();
    b_valid = 0;
    chk("t6_we_x0", rf_we, 0); chk("t6_wd_x0", rf_wd, 32'h1234);
    sb_set = 1; sb_rd = 20; rs2 = 20;
    step();
    sb_set = 0;
    a_valid = 1; a_rd = 21; a_data = 32'h2121;
    step();
    #1 chk("t6_busy20", busy_rs2, 1); chk("t6_we_pre", rf_we, 1);
    rst_n = 0;
    #1;
    chk("t6_rst_we", rf_we, 0); chk("t6_rst_wd", rf_wd, 0);
    chk("t6_rst_busy", busy_rs2, 0); chk("t6_rst_err", sb_err, 0);
    step();
    rst_n = 1;
    idle_inputs();

    // Randomized traffic with a mid-stream reset
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      if (cyc == 1500) rst_n = 0;
      if (cyc == 1503) rst_n = 1;
      if (!(a_valid && !m_acc_a)) begin
        a_valid = ($urandom_range(0, 9) < 7);
        a_rd    = 5'($urandom_range(0, 7));
        a_data  = $urandom;
      end
      if (!(b_valid && !m_acc_b)) begin
        b_valid = ($urandom_range(0, 9) < 4);
        b_rd    = 5'($urandom_range(0, 7));
        b_data  = $urandom;
      end
      sb_set = ($urandom_range(0, 3) == 0);
      sb_rd  = 5'($urandom_range(0, 7));
      rs1    = 5'($urandom_range(0, 7));
      rs2    = 5'($urandom_range(0, 7));
    end
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
